// File: rtl/conv_stream_src.sv
// rtl/conv_stream_src.sv - replays preloaded F/X buffers as handshaked frames
// Two independent valid/ready channels, frame repeat and optional LFSR valid throttling.
module conv_stream_src #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int FRAME_W      = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_en,
  input  logic                                    wr_sel,
  input  logic [$clog2(X_SIZE)-1:0]               wr_addr,
  input  logic [((DATA_WIDTH_X > DATA_WIDTH_F) ?
                 DATA_WIDTH_X : DATA_WIDTH_F)-1:0] wr_data,
  input  logic                                    start,
  input  logic [FRAME_W-1:0]                      num_frames,
  input  logic                                    throttle_en,
  output logic                                    m_valid_f,
  input  logic                                    m_ready_f,
  output logic signed [DATA_WIDTH_F-1:0]          m_data_f,
  output logic                                    m_valid_x,
  input  logic                                    m_ready_x,
  output logic signed [DATA_WIDTH_X-1:0]          m_data_x,
  output logic                                    busy,
  output logic                                    done
);

  localparam int FA_W = $clog2(F_SIZE);
  localparam int XA_W = $clog2(X_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  logic signed [DATA_WIDTH_F-1:0] r_fbuf [F_SIZE];
  logic signed [DATA_WIDTH_X-1:0] r_xbuf [X_SIZE];
  logic [FA_W-1:0]                r_idx_f;
  logic [XA_W-1:0]                r_idx_x;
  logic                           r_f_fin;
  logic                           r_x_fin;
  logic [FRAME_W-1:0]             r_frames_left;
  logic [7:0]                     r_lfsr;
  logic                           r_valid_f;
  logic                           r_valid_x;
  logic signed [DATA_WIDTH_F-1:0] r_data_f;
  logic signed [DATA_WIDTH_X-1:0] r_data_x;
  logic                           r_busy;
  logic                           r_done;

  logic                           w_allow_f;
  logic                           w_allow_x;
  logic                           w_f_xfer;
  logic                           w_x_xfer;
  logic                           w_f_last;
  logic                           w_x_last;
  logic                           w_frame_end;
  logic                           w_lfsr_fb;
  logic [FA_W-1:0]                w_f_nidx;
  logic [XA_W-1:0]                w_x_nidx;
  logic signed [DATA_WIDTH_F-1:0] w_f_word0;
  logic signed [DATA_WIDTH_X-1:0] w_x_word0;

  assign w_allow_f   = !throttle_en || r_lfsr[0];
  assign w_allow_x   = !throttle_en || r_lfsr[1];
  assign w_f_xfer    = r_valid_f && m_ready_f;
  assign w_x_xfer    = r_valid_x && m_ready_x;
  assign w_f_last    = w_f_xfer && (r_idx_f == FA_W'(F_SIZE - 1));
  assign w_x_last    = w_x_xfer && (r_idx_x == XA_W'(X_SIZE - 1));
  assign w_frame_end = (r_f_fin || w_f_last) && (r_x_fin || w_x_last);
  assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_f_nidx    = r_idx_f + FA_W'(1);
  assign w_x_nidx    = r_idx_x + XA_W'(1);

  // Bypass so a write to entry 0 in the start cycle is what goes out first.
  assign w_f_word0 = (wr_en && !wr_sel && (wr_addr[FA_W-1:0] == '0)) ?
                     wr_data[DATA_WIDTH_F-1:0] : r_fbuf[0];
  assign w_x_word0 = (wr_en && wr_sel && (wr_addr == '0)) ?
                     wr_data[DATA_WIDTH_X-1:0] : r_xbuf[0];

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && wr_en) begin
      if (wr_sel) r_xbuf[wr_addr] <= wr_data[DATA_WIDTH_X-1:0];
      else        r_fbuf[wr_addr[FA_W-1:0]] <= wr_data[DATA_WIDTH_F-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx_f       <= '0;
      r_idx_x       <= '0;
      r_f_fin       <= 1'b0;
      r_x_fin       <= 1'b0;
      r_frames_left <= '0;
      r_lfsr        <= 8'hA5;
      r_valid_f     <= 1'b0;
      r_valid_x     <= 1'b0;
      r_data_f      <= '0;
      r_data_x      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state       <= ST_RUN;
            r_busy        <= 1'b1;
            r_frames_left <= (num_frames == '0) ? FRAME_W'(1) : num_frames;
            r_idx_f       <= '0;
            r_idx_x       <= '0;
            r_f_fin       <= 1'b0;
            r_x_fin       <= 1'b0;
            r_valid_f     <= w_allow_f;
            r_valid_x     <= w_allow_x;
            r_data_f      <= w_allow_f ? w_f_word0 : '0;
            r_data_x      <= w_allow_x ? w_x_word0 : '0;
          end
        end
        ST_RUN: begin
          r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
          if (w_frame_end) begin
            r_idx_f <= '0;
            r_idx_x <= '0;
            r_f_fin <= 1'b0;
            r_x_fin <= 1'b0;
            if (r_frames_left == FRAME_W'(1)) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_valid_f <= 1'b0;
              r_valid_x <= 1'b0;
              r_data_f  <= '0;
              r_data_x  <= '0;
            end else begin
              r_frames_left <= r_frames_left - FRAME_W'(1);
              r_valid_f     <= w_allow_f;
              r_valid_x     <= w_allow_x;
              r_data_f      <= w_allow_f ? r_fbuf[0] : '0;
              r_data_x      <= w_allow_x ? r_xbuf[0] : '0;
            end
          end else begin
            // A stalled beat keeps valid/data; only a transfer or an idle channel moves.
            if (w_f_xfer) begin
              if (w_f_last) begin
                r_f_fin   <= 1'b1;
                r_valid_f <= 1'b0;
                r_data_f  <= '0;
              end else begin
                r_idx_f   <= w_f_nidx;
                r_valid_f <= w_allow_f;
                r_data_f  <= w_allow_f ? r_fbuf[w_f_nidx] : '0;
              end
            end else if (!r_valid_f && !r_f_fin) begin
              r_valid_f <= w_allow_f;
              r_data_f  <= w_allow_f ? r_fbuf[r_idx_f] : '0;
            end
            if (w_x_xfer) begin
              if (w_x_last) begin
                r_x_fin   <= 1'b1;
                r_valid_x <= 1'b0;
                r_data_x  <= '0;
              end else begin
                r_idx_x   <= w_x_nidx;
                r_valid_x <= w_allow_x;
                r_data_x  <= w_allow_x ? r_xbuf[w_x_nidx] : '0;
              end
            end else if (!r_valid_x && !r_x_fin) begin
              r_valid_x <= w_allow_x;
              r_data_x  <= w_allow_x ? r_xbuf[r_idx_x] : '0;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_valid_f = r_valid_f;
  assign m_valid_x = r_valid_x;
  assign m_data_f  = r_data_f;
  assign m_data_x  = r_data_x;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_conv_stream_src.sv
// tb/tb_conv_stream_src.sv - scoreboard bench for conv_stream_src
// Stimulus pushes expected beats/done cycles; a negedge monitor pops and compares.
module tb_conv_stream_src;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic              wr_sel;
  logic [6:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic [7:0]        num_frames;
  logic              throttle_en;
  logic              m_valid_f;
  logic              m_ready_f;
  logic signed [7:0] m_data_f;
  logic              m_valid_x;
  logic              m_ready_x;
  logic signed [7:0] m_data_x;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  conv_stream_src dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .num_frames  (num_frames),
    .throttle_en (throttle_en),
    .m_valid_f   (m_valid_f),
    .m_ready_f   (m_ready_f),
    .m_data_f    (m_data_f),
    .m_valid_x   (m_valid_x),
    .m_ready_x   (m_ready_x),
    .m_data_x    (m_data_x),
    .busy        (busy),
    .done        (done)
  );

  localparam int K_SNAP = 0, K_EMPTY = 1, K_GAP0 = 2, K_GAPN = 3, K_TMO = 4;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  exp_f[$];
  logic [7:0]  exp_x[$];
  int          exp_done[$];
  int          req_seq = 0;
  int          req_seen = 0;
  int          req_kind = 0;
  logic [19:0] req_val = '0;
  string       req_name = "";
  logic [19:0] snap;
  logic        mon_pvf = 1'b0, mon_pvx = 1'b0, mon_prf = 1'b0, mon_prx = 1'b0, mon_prst = 1'b0;
  logic [7:0]  mon_pdf = '0, mon_pdx = '0, mon_e = '0;
  int          mon_gap = 0;
  int          mon_d = 0;

  assign snap = {m_valid_f, m_valid_x, busy, done, m_data_f, m_data_x};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (req_seq != req_seen) begin
      req_seen = req_seq;
      checks++;
      case (req_kind)
        K_SNAP: if (snap !== req_val) begin
          failures++;
          $display("FAIL %s: outputs {vf,vx,busy,done,df,dx}=%h expected %h", req_name, snap, req_val);
        end
        K_EMPTY: if (exp_f.size() != 0 || exp_x.size() != 0 || exp_done.size() != 0) begin
          failures++;
          $display("FAIL %s: leftover f=%0d x=%0d done=%0d expected 0", req_name,
                   exp_f.size(), exp_x.size(), exp_done.size());
        end
        K_GAP0: if (mon_gap != 0) begin
          failures++;
          $display("FAIL %s: x gaps=%0d expected 0", req_name, mon_gap);
        end
        K_GAPN: if (mon_gap == 0) begin
          failures++;
          $display("FAIL %s: x gaps=%0d expected >0", req_name, mon_gap);
        end
        default: begin
          failures++;
          $display("FAIL %s: timeout waiting for done, got done=%b expected 1", req_name, done);
        end
      endcase
    end
    if (rst_n) begin
      if (mon_prst) begin
        if (mon_pvf && !mon_prf) begin
          checks++;
          if (!m_valid_f || m_data_f !== mon_pdf) begin
            failures++;
            $display("FAIL hold_f: got v=%b d=%0d expected v=1 d=%0d", m_valid_f, m_data_f, $signed(mon_pdf));
          end
        end
        if (mon_pvx && !mon_prx) begin
          checks++;
          if (!m_valid_x || m_data_x !== mon_pdx) begin
            failures++;
            $display("FAIL hold_x: got v=%b d=%0d expected v=1 d=%0d", m_valid_x, m_data_x, $signed(mon_pdx));
          end
        end
      end
      if (start && !busy) mon_gap = 0;
      else if (busy && !m_valid_x) mon_gap++;
      if (m_valid_f && m_ready_f) begin
        checks++;
        if (exp_f.size() == 0) begin
          failures++;
          $display("FAIL beat_f: got unexpected %0d expected none", m_data_f);
        end else begin
          mon_e = exp_f.pop_front();
          if (m_data_f !== mon_e) begin
            failures++;
            $display("FAIL beat_f: got %0d expected %0d", m_data_f, $signed(mon_e));
          end
        end
      end
      if (m_valid_x && m_ready_x) begin
        checks++;
        if (exp_x.size() == 0) begin
          failures++;
          $display("FAIL beat_x: got unexpected %0d expected none", m_data_x);
        end else begin
          mon_e = exp_x.pop_front();
          if (m_data_x !== mon_e) begin
            failures++;
            $display("FAIL beat_x: got %0d expected %0d", m_data_x, $signed(mon_e));
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL done: got unexpected pulse at cycle %0d expected none", cyc);
        end else begin
          mon_d = exp_done.pop_front();
          if ((mon_d >= 0 && mon_d != cyc) || busy || m_valid_f || m_valid_x) begin
            failures++;
            $display("FAIL done: got cycle %0d busy=%b vf=%b vx=%b expected cycle %0d busy=0 valids=0",
                     cyc, busy, m_valid_f, m_valid_x, mon_d);
          end
        end
      end
    end
    mon_pvf  = m_valid_f;
    mon_pvx  = m_valid_x;
    mon_prf  = m_ready_f;
    mon_prx  = m_ready_x;
    mon_pdf  = m_data_f;
    mon_pdx  = m_data_x;
    mon_prst = rst_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int kind, input logic [19:0] val, input string name);
    req_kind = kind;
    req_val  = val;
    req_name = name;
    req_seq++;
    tick(1);
  endtask

  task automatic push_frame(input logic [7:0] f0);
    for (int i = 0; i < 32; i++) exp_f.push_back((i == 0) ? f0 : 8'(i - 16));
    for (int i = 0; i < 128; i++) exp_x.push_back(8'(i - 64));
  endtask

  task automatic do_start(input logic [7:0] nf);
    num_frames = nf;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin
      tick(1);
      n++;
    end
    if (!done) req(K_TMO, '0, name);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; num_frames = 8'd1; throttle_en = 1'b0;
    m_ready_f = 1'b1; m_ready_x = 1'b1;
    tick(2);
    req(K_SNAP, 20'h0, "reset_outputs");
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'(i); wr_data = 8'(i - 16);
      tick(1);
    end
    for (int i = 0; i < 128; i++) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 7'(i); wr_data = 8'(i - 64);
      tick(1);
    end
    wr_en = 1'b0;
    tick(1);

    // basic single frame
    push_frame(8'hF0);
    exp_done.push_back(cyc + 129);
    do_start(8'd1);
    req(K_SNAP, {4'b1110, 8'hF0, 8'hC0}, "s1_first_beat");
    wait_done(300, "s1_done");
    tick(2);
    req(K_GAP0, '0, "s1_x_gaps");
    req(K_EMPTY, '0, "s1_drain");

    // backpressure
    push_frame(8'hF0);
    exp_done.push_back(-1);
    do_start(8'd1);
    for (int c = 0; c < 3000; c++) begin
      m_ready_x = (c % 2 == 0) ? 1'b0 : 1'b1;
      m_ready_f = (c >= 5 && c < 15) ? 1'b0 : 1'b1;
      tick(1);
      if (done) break;
    end
    if (!done) req(K_TMO, '0, "s2_done");
    m_ready_f = 1'b1; m_ready_x = 1'b1;
    tick(2);
    req(K_EMPTY, '0, "s2_drain");

    // three frames
    push_frame(8'hF0); push_frame(8'hF0); push_frame(8'hF0);
    exp_done.push_back(cyc + 385);
    do_start(8'd3);
    tick(127);
    req(K_SNAP, {4'b0110, 8'h00, 8'h3F}, "s3_cycle128");
    req(K_SNAP, {4'b1110, 8'hF0, 8'hC0}, "s3_frame2_start");
    tick(127);
    req(K_SNAP, {4'b1110, 8'hF0, 8'hC0}, "s3_frame3_start");
    wait_done(600, "s3_done");
    tick(2);
    req(K_GAP0, '0, "s3_x_gaps");
    req(K_EMPTY, '0, "s3_drain");

    // throttle
    throttle_en = 1'b1;
    push_frame(8'hF0);
    exp_done.push_back(-1);
    do_start(8'd1);
    wait_done(2000, "s4_done");
    tick(2);
    throttle_en = 1'b0;
    req(K_GAPN, '0, "s4_x_gaps");
    req(K_EMPTY, '0, "s4_drain");

    // reset mid-run
    push_frame(8'hF0);
    do_start(8'd1);
    tick(48);
    rst_n = 1'b0;
    tick(1);
    req(K_SNAP, 20'h0, "s5_reset_outputs");
    rst_n = 1'b1;
    exp_f.delete();
    exp_x.delete();
    tick(3);
    req(K_SNAP, 20'h0, "s5_idle_after_reset");
    push_frame(8'hF0);
    exp_done.push_back(cyc + 129);
    do_start(8'd1);
    req(K_SNAP, {4'b1110, 8'hF0, 8'hC0}, "s5_restart_first");
    wait_done(300, "s5_done");
    tick(2);
    req(K_EMPTY, '0, "s5_drain");

    // num_frames=0, write+start together, start and writes during RUN
    push_frame(8'h2A);
    exp_done.push_back(cyc + 129);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd0; wr_data = 8'h2A;
    do_start(8'd0);
    wr_en = 1'b0;
    tick(8);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd31; wr_data = 8'd99;
    tick(1);
    wr_sel = 1'b1; wr_addr = 7'd100; wr_data = 8'd77;
    tick(1);
    wr_en = 1'b0;
    wait_done(300, "s6_done");
    tick(2);
    req(K_EMPTY, '0, "s6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_src.md
Name: conv_stream_src

Overview:
- Stream master that drives the slave side of the convolution core: the F channel (valid/ready/data) and the X channel (valid/ready/data).
- Coefficients (F_SIZE words) and samples (X_SIZE words) are preloaded into internal register buffers through a simple write port.
- On start, the block replays one or more frames. Each frame sends F_SIZE F words and X_SIZE X words on independent handshaked channels.
- Used as the on-chip stimulus source in front of the convolution core, with optional pseudo-random valid throttling.

Parameters:
- DATA_WIDTH_X, 8, X sample width.
- DATA_WIDTH_F, 8, F coefficient width.
- X_SIZE, 128, X words per frame.
- F_SIZE, 32, F words per frame.
- FRAME_W, 8, width of the frame-count input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  0 = F buffer, 1 = X buffer.
- wr_addr  in  $clog2(X_SIZE)  write address; for the F buffer only the low $clog2(F_SIZE) bits are used.
- wr_data  in  max(DATA_WIDTH_X, DATA_WIDTH_F)  write data; low bits are used.
- start  in  1  one-cycle request to begin streaming.
- num_frames  in  FRAME_W  number of frames; 0 is treated as 1.
- throttle_en  in  1  enable pseudo-random valid gaps.
- m_valid_f  out  1  F channel valid.
- m_ready_f  in  1  F channel ready.
- m_data_f  out  DATA_WIDTH_F signed  F channel data.
- m_valid_x  out  1  X channel valid.
- m_ready_x  in  1  X channel ready.
- m_data_x  out  DATA_WIDTH_X signed  X channel data.
- busy  out  1  streaming in progress.
- done  out  1  one-cycle pulse after the last beat of the last frame.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - m_valid_f, m_valid_x, busy, done, m_data_f, m_data_x all = 0.
  - FSM returns to IDLE; channel indices and frame counter = 0; LFSR = 8'hA5.
  - Buffer contents are not reset.
  - Reset mid-stream aborts immediately: valids drop the next cycle and no done pulse is produced.
- FSM states:
  - IDLE: wr_en writes the addressed buffer entry. start = 1 latches num_frames (0 becomes 1) and moves to RUN.
  - RUN: wr_en and start are ignored; buffers are frozen.
  - On the final beat of the final frame, move to DONE.
  - DONE: lasts one cycle with done = 1, then returns to IDLE.
- busy is 1 in RUN only.
- Transfer rule: a beat transfers on a rising edge where valid & ready = 1.
- Valid/data hold rule: once valid = 1, valid and data are held stable until that beat transfers. valid never drops without a transfer, except on reset.
- Latency:
  - start sampled at edge N gives m_valid_f = m_valid_x = 1 from cycle N+1, carrying word 0 of each buffer (throttle off).
  - With ready held high, one beat transfers per cycle per channel.
  - Consecutive words are sent back-to-back with no bubble.
- Each channel sends words 0..SIZE-1 in address order, then holds valid = 0 for the rest of the frame.
- Frame boundary:
  - The frame ends at the edge where the later of the two channels transfers its last word.
  - At that same edge both indices reset to 0. If frames remain, both valids are asserted for word 0 of the next frame from the next cycle.
  - The channel that finished later therefore sees no bubble between frames.
  - The F words are resent every frame.
- Completion: after the last frame's final beat, busy = 0 and done = 1 in the following cycle.
- Throttle:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle while in RUN.
  - When throttle_en = 1, a channel whose valid is currently 0 may raise valid only in a cycle where the LFSR bit 0 = 1. The F channel uses bit 0; the X channel uses bit 1.
  - The throttle never drops a valid that is already asserted.
  - When throttle_en = 0, the LFSR has no effect.
- Simultaneous events:
  - wr_en and start in the same IDLE cycle: the write is performed and then streaming starts, so the written value is sent.
  - start while in RUN or DONE is ignored.

Test Plan:
- F buffer loaded with F[i] = i-16, X buffer with X[i] = i-64. Both readys held high, num_frames = 1, start. Required:
  - F words -16..15 on cycles 1..32.
  - X words -64..63 on cycles 1..128.
  - done = 1 on cycle 129; busy falls at the same time.
- As above, but m_ready_x toggles 1,0,1,0 and m_ready_f is held low for 10 cycles mid-frame. Required:
  - Data held stable whenever valid = 1 and ready = 0.
  - All 128 X words and 32 F words are delivered in order with none lost or duplicated.
  - done asserts exactly once.
- num_frames = 3 with readys high. Required:
  - 96 F beats and 384 X beats.
  - The X channel shows no bubble at frame boundaries.
  - F resumes at word 0 exactly at each X frame-end edge.
  - done on cycle 385.
- throttle_en = 1, readys high. Required:
  - Gaps appear in valid.
  - No valid falls without a transfer.
  - The beat sequence is identical to the first scenario.
- rst_n pulled low at cycle 50 of a run. Required:
  - All outputs are 0 the next cycle and no done pulse occurs.
  - A new start after reset streams from word 0, and the buffer contents are intact.
- num_frames = 0, and start pulsed again at cycle 10 of the run. Required:
  - Exactly one frame is sent; the second start is ignored.
  - A wr_en issued during RUN does not change the streamed data.
